// File: rtl/stream_arb_pkg.sv
// rtl/stream_arb_pkg.sv - shared types and width helper for the stream round-robin arbiter
package stream_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index width that stays at least one bit wide for degenerate counts.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotated priority encoder: first set request at or above ptr, wrapping
module rr_pick
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        int j;
        j   = 0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[j]) begin
                any = 1'b1;
                idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - round-robin burst arbiter sharing one ready/valid sink
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    input  logic                          out_ready,
    output logic [idx_width(NUM_REQ)-1:0] grant_id,
    output logic                          busy
);

    localparam int ID_W  = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;
    logic             beat;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Outputs are pure functions of state and inputs, so reset forces them low at once.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        out_valid  = 1'b0;
        out_data   = '0;
        req_ready  = '0;
        busy       = 1'b0;
        beat       = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                busy                  = 1'b1;
                out_valid             = req_valid[grant_id_q];
                out_data              = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
                req_ready[grant_id_q] = out_ready;
                beat                  = out_valid && out_ready;
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (req_last[grant_id_q] || (beat_cnt_q == CNT_W'(MAX_BURST - 1))) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0
                                                                       : grant_id_q + ID_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_id = grant_id_q;

endmodule
